// File: rtl/fp_result_fifo.sv
// Result FIFO behind the FP add/mul unit: tags each result with NaN/Inf/zero/subnormal
// flags on entry and hands entries to a possibly stalling consumer over valid/ready.
module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         Resultado,
    input  logic                     OP_input,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_op,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 5;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_dropErr;

    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_exp;
    logic [22:0]   w_man;
    logic [3:0]    w_flags;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;
    assign drop_err  = r_dropErr;

    // Classification is done once at enqueue so the consumer sees flags with zero extra latency.
    assign w_exp   = Resultado[30:23];
    assign w_man   = Resultado[22:0];
    assign w_flags = {(w_exp == 8'hFF) && (w_man != '0),
                      (w_exp == 8'hFF) && (w_man == '0),
                      (w_exp == 8'h00) && (w_man == '0),
                      (w_exp == 8'h00) && (w_man != '0)};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {Resultado, OP_input, w_flags};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_dropErr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // Sticky until reset, even when a pop frees a slot in the same cycle.
            if (in_valid && !in_ready) begin
                r_dropErr <= 1'b1;
            end
        end
    end

    always_comb begin
        out_result = '0;
        out_op     = 1'b0;
        out_flags  = '0;
        if (out_valid) begin
            {out_result, out_op, out_flags} = r_mem[r_rdPtr];
        end
    end

endmodule

// File: tb/tb_fp_result_fifo.sv
// Scoreboard bench for fp_result_fifo: the driver queues expected entries as words are
// accepted, and a separate monitor compares every presented head entry against that queue.
module tb_fp_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] result;
        logic        op;
        logic [3:0]  flags;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  Resultado = '0;
    logic              OP_input = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_result;
    logic              out_op;
    logic [3:0]        out_flags;
    logic [2:0]        count;
    logic              drop_err;

    entry_t expQ[$];
    int     modelCount = 0;
    bit     modelDrop  = 1'b0;
    bit     checksOn   = 1'b0;
    int     errors     = 0;
    int     checks     = 0;

    fp_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Resultado  (Resultado),
        .OP_input   (OP_input),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_flags  (out_flags),
        .count      (count),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    // Reference classification from the IEEE-754 field definitions.
    function automatic logic [3:0] classify(input logic [31:0] w);
        int e;
        int m;
        e = int'(w[30:23]);
        m = int'(w[22:0]);
        if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] randomWord();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom_range(1, 32'h7FFFFF));
        case ($urandom_range(0, 5))
            0:       return {s, 8'hFF, m};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'h00, 23'd0};
            3:       return {s, 8'h00, m};
            4:       return {s, 8'($urandom_range(1, 254)), m};
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check status mid-cycle, then advance the model.
    task automatic applyStimulus(input bit doRst, input bit v, input logic [31:0] word,
                                 input bit op, input bit rdy);
        bit     push;
        bit     pop;
        entry_t e;
        @(posedge clk);
        #1;
        rst       = doRst;
        in_valid  = v;
        Resultado = v ? word : 32'hxxxxxxxx;
        OP_input  = op;
        out_ready = rdy;
        @(negedge clk);
        if (checksOn) begin
            checkOutput("count", 32'(count), 32'(modelCount));
            checkOutput("in_ready", 32'(in_ready), 32'(modelCount != DEPTH));
            checkOutput("out_valid", 32'(out_valid), 32'(modelCount != 0));
            checkOutput("drop_err", 32'(drop_err), 32'(modelDrop));
        end
        if (doRst) begin
            expQ.delete();
            modelCount = 0;
            modelDrop  = 1'b0;
            checksOn   = 1'b1;
        end else begin
            pop  = (modelCount > 0) && rdy;
            push = v && (modelCount < DEPTH);
            if (v && !push) modelDrop = 1'b1;
            if (push) begin
                e.result = word;
                e.op     = op;
                e.flags  = classify(word);
                expQ.push_back(e);
            end
            modelCount = modelCount + int'(push) - int'(pop);
        end
    endtask

    // Monitor: compares the presented head against the scoreboard and retires it on a handshake.
    always begin
        @(negedge clk);
        #1;
        if (checksOn && !rst) begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("out_result", out_result, expQ[0].result);
                    checkOutput("out_op", 32'(out_op), 32'(expQ[0].op));
                    checkOutput("out_flags", 32'(out_flags), 32'(expQ[0].flags));
                    if (out_ready) void'(expQ.pop_front());
                end
            end else begin
                checkOutput("idle_outputs", out_result | 32'(out_op) | 32'(out_flags), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] specials [4];
        specials = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000001};

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 1, 32'h3F800000, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, specials[i], i[0], 0);
        applyStimulus(0, 1, 32'h40490FDB, 1, 0);
        applyStimulus(0, 1, 32'h40490FDB, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);

        for (int i = 0; i < 10; i++) applyStimulus(0, 1, randomWord(), 1'($urandom_range(0, 1)), 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 1, 32'h3F800000, 0, 0);
        applyStimulus(0, 1, 32'h40000000, 1, 0);
        applyStimulus(0, 1, 32'h40400000, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, randomWord(), 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 1, 32'h41200000, 1, 0);
        applyStimulus(0, 1, 32'h41300000, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);

        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, randomWord(),
                          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 5);
        end
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
